// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the dual-port RAM arbiter.
// Tags follow each granted read through the fixed RAM latency.
package ram_arb_pkg;

    localparam int ID_W = 4;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    function automatic int rd_latency(int reg_rd_data);
        return 1 + ((reg_rd_data != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/ram_tdp_arbiter_if.sv
// Requester-side bus of the RAM arbiter: per-requester request and response lanes.
interface ram_tdp_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0]                 req_wr;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wr_data;
    logic [NUM_REQ-1:0]                 resp_valid;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] resp_data;

    modport master (
        output req_valid, req_wr, req_addr, req_wr_data,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wr_data,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/rr_priority_select.sv
// Cyclic priority picker: first set request at or after start_i, wrapping around.
module rr_priority_select #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);
    int unsigned j;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found_o = 1'b0;
        j       = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(start_i) + i) % N;
            if (!found_o && req_i[j]) begin
                found_o  = 1'b1;
                idx_o    = IDX_W'(j);
                gnt_o[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ram_tdp_arbiter.sv
// Round-robin arbiter granting up to two requests per cycle onto a true-dual-port RAM,
// with same-address write hazard blocking and fixed-latency read return.
module ram_tdp_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int REG_RD_DATA = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_tdp_arbiter_if.slave      bus,
    output logic                  ram_en_a,
    output logic                  ram_en_b,
    output logic                  ram_wr_en_a,
    output logic                  ram_wr_en_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH-1:0] ram_wr_data_a,
    output logic [DATA_WIDTH-1:0] ram_wr_data_b,
    input  logic [DATA_WIDTH-1:0] ram_rd_data_a,
    input  logic [DATA_WIDTH-1:0] ram_rd_data_b
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LAT   = rd_latency(REG_RD_DATA);

    typedef logic [IDX_W-1:0] idx_t;

    function automatic idx_t next_idx(idx_t i);
        return (int'(i) >= NUM_REQ - 1) ? '0 : idx_t'(int'(i) + 1);
    endfunction

    logic               en_q;
    idx_t               rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] req_vec, mask_b, gnt_a, gnt_b;
    idx_t               idx_a, idx_b;
    logic               found_a, found_b, hazard, grant_b;
    tag_t               new_a, new_b;
    tag_t               tag_a_q [LAT];
    tag_t               tag_b_q [LAT];

    // No grants until the first edge after reset, so the RAM is never driven while disabled.
    assign req_vec = en_q ? bus.req_valid : '0;
    assign mask_b  = req_vec & ~gnt_a;

    rr_priority_select #(.N(NUM_REQ), .IDX_W(IDX_W)) u_sel_a (
        .req_i   (req_vec),
        .start_i (rr_ptr_q),
        .gnt_o   (gnt_a),
        .idx_o   (idx_a),
        .found_o (found_a)
    );

    rr_priority_select #(.N(NUM_REQ), .IDX_W(IDX_W)) u_sel_b (
        .req_i   (mask_b),
        .start_i (next_idx(idx_a)),
        .gnt_o   (gnt_b),
        .idx_o   (idx_b),
        .found_o (found_b)
    );

    assign hazard  = found_a && found_b
                  && (bus.req_addr[idx_a] == bus.req_addr[idx_b])
                  && (bus.req_wr[idx_a] || bus.req_wr[idx_b]);
    assign grant_b = found_b && !hazard;

    assign bus.req_ready = gnt_a | (grant_b ? gnt_b : '0);

    // A withdrawn B candidate becomes the next start so it wins port A next cycle.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (hazard)
            rr_ptr_d = idx_b;
        else if (grant_b)
            rr_ptr_d = next_idx(idx_b);
        else if (found_a)
            rr_ptr_d = next_idx(idx_a);
    end

    assign ram_en_a      = en_q;
    assign ram_en_b      = en_q;
    assign ram_wr_en_a   = found_a && bus.req_wr[idx_a];
    assign ram_wr_en_b   = grant_b && bus.req_wr[idx_b];
    assign ram_addr_a    = found_a ? bus.req_addr[idx_a]    : '0;
    assign ram_addr_b    = grant_b ? bus.req_addr[idx_b]    : '0;
    assign ram_wr_data_a = found_a ? bus.req_wr_data[idx_a] : '0;
    assign ram_wr_data_b = grant_b ? bus.req_wr_data[idx_b] : '0;

    assign new_a.valid = found_a && !bus.req_wr[idx_a];
    assign new_a.id    = ID_W'(idx_a);
    assign new_b.valid = grant_b && !bus.req_wr[idx_b];
    assign new_b.id    = ID_W'(idx_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q     <= 1'b0;
            rr_ptr_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_a_q[i] <= '0;
                tag_b_q[i] <= '0;
            end
        end else begin
            en_q       <= 1'b1;
            rr_ptr_q   <= rr_ptr_d;
            tag_a_q[0] <= new_a;
            tag_b_q[0] <= new_b;
            for (int i = 1; i < LAT; i++) begin
                tag_a_q[i] <= tag_a_q[i-1];
                tag_b_q[i] <= tag_b_q[i-1];
            end
        end
    end

    // A requester has at most one read in any pipeline slot, so ports never collide on a lane.
    always_comb begin
        bus.resp_valid = '0;
        bus.resp_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tag_a_q[LAT-1].valid && tag_a_q[LAT-1].id == ID_W'(i)) begin
                bus.resp_valid[i] = 1'b1;
                bus.resp_data[i]  = ram_rd_data_a;
            end
            if (tag_b_q[LAT-1].valid && tag_b_q[LAT-1].id == ID_W'(i)) begin
                bus.resp_valid[i] = 1'b1;
                bus.resp_data[i]  = ram_rd_data_b;
            end
        end
    end
endmodule

// File: doc/ram_tdp_arbiter.md
Name: ram_tdp_arbiter

Overview:
- Shares one true-dual-port RAM (two ports, single clock, read-first per port, optional output register) between NUM_REQ requesters.
- Each cycle it grants up to two requests, one per RAM port, using round-robin order.
- It blocks same-address hazards between the two ports and returns read data to the issuing requester after the fixed RAM latency.
- It sits between client engines and the RAM instance, and drives the RAM port pins directly.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, RAM word width.
- ADDR_WIDTH, 10, RAM address width.
- REG_RD_DATA, 1, must match the RAM's setting. Read latency is 1 + REG_RD_DATA cycles.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; a request transfers when valid & ready.
- req_wr  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ x ADDR_WIDTH  request address.
- req_wr_data  in  NUM_REQ x DATA_WIDTH  write data.
- resp_valid  out  NUM_REQ  read data valid, one-cycle pulse.
- resp_data  out  NUM_REQ x DATA_WIDTH  read data; meaningful only when resp_valid is high.
- ram_en_a, ram_en_b  out  1  RAM port enables.
- ram_wr_en_a, ram_wr_en_b  out  1  RAM write enables.
- ram_addr_a, ram_addr_b  out  ADDR_WIDTH  RAM addresses.
- ram_wr_data_a, ram_wr_data_b  out  DATA_WIDTH  RAM write data.
- ram_rd_data_a, ram_rd_data_b  in  DATA_WIDTH  RAM read data.

Behaviour:
- Reset: rr_ptr = 0; all tag-pipeline entries invalid; resp_valid = 0; ram_en_a/b = 0; ram_wr_en_a/b = 0.
- ram_en_a/b are 1 in every cycle after reset. The RAM output register is gated by en, so holding enable high keeps the read pipeline advancing.
- An idle port performs a dummy read of address 0 (wr_en = 0). No response is tracked for a dummy read.
- Grant selection is combinational within the cycle:
  - Port A goes to the first valid requester at or after rr_ptr, searching cyclically.
  - Port B goes to the next valid requester cyclically after A's grantee.
  - req_ready = grant. req_ready depends combinationally on req_valid, so requesters must not derive valid from ready.
- Hazard rule: if A and B grantees have equal addresses and at least one is a write, port B's grant is withdrawn that cycle. The B candidate is not granted and gets first priority next cycle through the pointer rule. Read/read to the same address is allowed.
- Pointer update on a registered edge:
  - If any grant occurred, rr_ptr = (last granted index + 1) mod NUM_REQ, where last granted is B if B was granted, else A.
  - No grant leaves rr_ptr unchanged.
  - If B was withdrawn by the hazard rule, rr_ptr = the withdrawn B index.
- Port mapping: a granted request drives that port's addr, wr_data and wr_en = req_wr in the same cycle it is granted. There is no request register.
- Tag pipeline:
  - Each port has a shift register of depth 1 + REG_RD_DATA holding {valid, requester id}.
  - valid is set only for granted reads.
  - At the pipeline tail, resp_valid[id] = 1 and resp_data[id] = that port's ram_rd_data.
- Responses are never back-pressured. A requester can receive at most one response per cycle, because it issues at most one request per cycle and latency is fixed.
- Ordering:
  - Writes are visible to any read granted in a later cycle.
  - A same-cycle read/write pair on the same address is impossible (hazard rule).
- Reset mid-operation drops in-flight reads. No resp_valid pulses occur after reset is released until new grants are made.
- NUM_REQ == 1: port B is never used.
- resp_data for non-responding lanes is 0.

Decomposition:
- Package ram_arb_pkg holds:
  - a localparam function rd_latency(REG_RD_DATA);
  - typedef tag_t = struct { logic valid; logic [$clog2(NUM_REQ)-1:0] id; }, parameterised via a width constant.
- One sub-module, rr_priority_select: NUM_REQ-wide request vector plus start index in, one-hot grant plus index plus found flag out. It is instantiated twice: A starting at rr_ptr, B starting at A index + 1 with A's bit masked.

Test Plan:
- Single write then read: requester 0 writes 0xDEAD_BEEF to addr 5, then reads addr 5. resp_valid[0] pulses exactly 2 cycles after the read grant (REG_RD_DATA = 1) with 0xDEAD_BEEF. Repeat with REG_RD_DATA = 0 and expect 1 cycle.
- Fairness: all 4 requesters hold valid reads to distinct addresses continuously. Grants are (0,1), (2,3), (0,1)…, and each requester is granted once per 2 cycles.
- Hazard: requester 0 writes addr 7 and requester 1 reads addr 7 in the same cycle. Only 0 is granted. Next cycle 1 is granted on port A and returns the new data.
- Read/read same address: requesters 2 and 3 read addr 9 together. Both are granted in the same cycle, and both get the same data with the same latency.
- Reset mid-flight: assert rst_n = 0 one cycle after granting two reads. No resp_valid afterwards; ram_en = 0 during reset; after release the first grant goes to requester 0.
- Idle: no requests for 10 cycles. ram_wr_en_a/b = 0, ram_addr = 0, and resp_valid stays 0 throughout.
